epb_remove_pack: RTL and testbench

Parametrised emulation-prevention-byte remover and repacker for the NAL byte-stream front end. It scans BYTES-wide words MSB byte first, drops every 0x03 that follows two zero bytes, including patterns that straddle words, and repacks the surviving bytes into dense BYTES-wide output words. On end of NAL it flushes a final partial word with a valid-byte count, and it reports the number of removed bytes per NAL. It sits between the NAL fetch FIFO and the bitstream shifter.

---
 rtl/epb_pkg.sv | 17 +
 rtl/epb_remove_pack_if.sv | 33 +++
 rtl/epb_scan.sv | 55 +++++
 rtl/epb_remove_pack.sv | 145 ++++++++++++++
 tb/tb_epb_remove_pack.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/epb_pkg.sv
// Shared constants, FSM state type and width helper for the emulation-prevention-byte remover.
package epb_pkg;

    localparam logic [7:0] EPB_BYTE  = 8'h03;
    localparam logic [7:0] ZERO_BYTE = 8'h00;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    // Width of a byte-count field able to hold 0..bytes.
    function automatic int unsigned cnt_width(input int unsigned bytes);
        return $clog2(bytes + 1);
    endfunction

endpackage

// File: rtl/epb_remove_pack_if.sv
// Input-word and output-word handshake bundle between NAL fetch, EPB remover and bitstream shifter.
interface epb_remove_pack_if
    import epb_pkg::*;
#(
    parameter int unsigned BYTES = 2
) ();

    localparam int unsigned CW = cnt_width(BYTES);

    logic               ai_we;
    logic               ai_first;
    logic               ai_last;
    logic [CW-1:0]      ai_bytes;
    logic [8*BYTES-1:0] ai_data;
    logic               ao_next;

    logic               bo_we;
    logic [8*BYTES-1:0] bo_data;
    logic               bo_last;
    logic [CW-1:0]      bo_bytes;
    logic               bi_next;

    modport master (
        output ai_we, ai_first, ai_last, ai_bytes, ai_data, bi_next,
        input  ao_next, bo_we, bo_data, bo_last, bo_bytes
    );

    modport slave (
        input  ai_we, ai_first, ai_last, ai_bytes, ai_data, bi_next,
        output ao_next, bo_we, bo_data, bo_last, bo_bytes
    );

endinterface

// File: rtl/epb_scan.sv
// Combinational scan of one word: drops 0x03 after two zero bytes and compacts the survivors MSB-first.
module epb_scan
    import epb_pkg::*;
#(
    parameter int unsigned BYTES = 2,
    localparam int unsigned CW = cnt_width(BYTES)
) (
    input  logic [8*BYTES-1:0] word_i,
    input  logic [CW-1:0]      nbytes_i,
    input  logic [1:0]         zrun_i,
    input  logic               en_i,
    output logic [BYTES-1:0]   keep_o,
    output logic [8*BYTES-1:0] kept_data_o,
    output logic [CW-1:0]      kept_cnt_o,
    output logic [1:0]         zrun_o,
    output logic [CW-1:0]      removed_o
);

    logic [1:0]  z;
    logic [7:0]  b;
    int unsigned nk;
    int unsigned nr;

    // keep_o bit i corresponds to byte i (byte 0 is the MSB byte of the word)
    always_comb begin
        z           = zrun_i;
        b           = '0;
        nk          = 0;
        nr          = 0;
        keep_o      = '0;
        kept_data_o = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            b = word_i[8*(BYTES-1-i) +: 8];
            if (i < 32'(nbytes_i)) begin
                if (en_i && (z == 2'd2) && (b == EPB_BYTE)) begin
                    nr++;
                    z = 2'd0;
                end else begin
                    keep_o[i] = 1'b1;
                    kept_data_o[8*(BYTES-1-nk) +: 8] = b;
                    nk++;
                    if (b == ZERO_BYTE) begin
                        z = (z == 2'd2) ? 2'd2 : z + 2'd1;
                    end else begin
                        z = 2'd0;
                    end
                end
            end
        end
        kept_cnt_o = CW'(nk);
        removed_o  = CW'(nr);
        zrun_o     = z;
    end

endmodule

// File: rtl/epb_remove_pack.sv
// EPB remover and repacker: scans accepted words, appends kept bytes to a 2*BYTES pack buffer
// and emits dense words, flushing a final partial word at end of NAL.
module epb_remove_pack
    import epb_pkg::*;
#(
    parameter int unsigned BYTES = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              epb_en,
    epb_remove_pack_if.slave  bus,
    output logic [CNT_W-1:0]  epb_cnt
);

    localparam int unsigned CW    = cnt_width(BYTES);
    localparam int unsigned DEPTH = 2 * BYTES;
    localparam int unsigned FW    = $clog2(DEPTH);

    state_t           state_q, state_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [1:0]       zrun_q, zrun_d;
    logic             en_q, en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       buf_q [DEPTH];
    logic [7:0]       buf_d [DEPTH];

    logic [CW-1:0]      scan_nbytes;
    logic [1:0]         scan_zrun_in;
    logic               scan_en;
    logic [BYTES-1:0]   keep;
    logic [8*BYTES-1:0] kept_data;
    logic [CW-1:0]      kept_cnt;
    logic [1:0]         scan_zrun;
    logic [CW-1:0]      removed;

    int unsigned      fill;
    int unsigned      out_n;
    int unsigned      popped;
    int unsigned      base;
    int unsigned      next_fill;
    logic             pop;
    logic             acc;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W:0]   cnt_sum;

    // A first word restarts the zero run and picks up the fresh enable immediately.
    assign scan_nbytes  = bus.ai_last  ? bus.ai_bytes : CW'(BYTES);
    assign scan_zrun_in = bus.ai_first ? 2'd0 : zrun_q;
    assign scan_en      = bus.ai_first ? epb_en : en_q;

    epb_scan #(
        .BYTES (BYTES)
    ) u_scan (
        .word_i      (bus.ai_data),
        .nbytes_i    (scan_nbytes),
        .zrun_i      (scan_zrun_in),
        .en_i        (scan_en),
        .keep_o      (keep),
        .kept_data_o (kept_data),
        .kept_cnt_o  (kept_cnt),
        .zrun_o      (scan_zrun),
        .removed_o   (removed)
    );

    always_comb begin
        fill         = 32'(fill_q);
        out_n        = (fill < BYTES) ? fill : BYTES;
        bus.bo_we    = (state_q == FLUSH) || (fill >= BYTES);
        bus.bo_last  = (state_q == FLUSH) && (fill <= BYTES);
        bus.bo_bytes = bus.bo_we ? CW'(out_n) : '0;
        bus.bo_data  = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (i < out_n) begin
                bus.bo_data[8*(BYTES-1-i) +: 8] = buf_q[i];
            end
        end
        pop         = bus.bo_we && bus.bi_next;
        bus.ao_next = (state_q == RUN) && ((fill < BYTES) || pop);
        acc         = bus.ai_we && bus.ao_next;
    end

    always_comb begin
        popped    = pop ? out_n : 0;
        base      = fill - popped;
        next_fill = base;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            buf_d[j] = '0;
            if (j + popped < fill) begin
                buf_d[j] = buf_q[j + popped];
            end
        end
        // Kept bytes land right behind whatever survives this cycle's pop.
        if (acc && (|keep)) begin
            for (int unsigned k = 0; k < BYTES; k++) begin
                if (k < 32'(kept_cnt)) begin
                    buf_d[base + k] = kept_data[8*(BYTES-1-k) +: 8];
                end
            end
            next_fill = base + 32'(kept_cnt);
        end
        fill_d = FW'(next_fill);

        zrun_d   = acc ? scan_zrun : zrun_q;
        en_d     = (acc && bus.ai_first) ? epb_en : en_q;
        cnt_base = bus.ai_first ? '0 : cnt_q;
        cnt_sum  = {1'b0, cnt_base} + (CNT_W+1)'(removed);
        cnt_d    = cnt_q;
        if (acc) begin
            cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end

        state_d = state_q;
        unique case (state_q)
            RUN:     if (acc && bus.ai_last) state_d = FLUSH;
            FLUSH:   if (pop && bus.bo_last) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            fill_q  <= '0;
            zrun_q  <= '0;
            en_q    <= 1'b1;
            cnt_q   <= '0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                buf_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            zrun_q  <= zrun_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                buf_q[j] <= buf_d[j];
            end
        end
    end

    assign epb_cnt = cnt_q;

endmodule

// File: tb/tb_epb_remove_pack.sv
// Self-checking bench for epb_remove_pack with BYTES=2: directed vector table, reset and stall sequences,
// and random NALs against a byte-list reference model.
module tb_epb_remove_pack;

    localparam int unsigned B  = 2;
    localparam int unsigned W  = 8 * B;
    localparam int unsigned CW = $clog2(B + 1);

    logic        clk = 1'b0;
    logic        reset;
    logic        epb_en;
    logic [15:0] epb_cnt;

    always #5 clk = ~clk;

    epb_remove_pack_if #(.BYTES(B)) bus ();

    epb_remove_pack #(
        .BYTES (B),
        .CNT_W (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .epb_en  (epb_en),
        .bus     (bus),
        .epb_cnt (epb_cnt)
    );

    typedef struct {
        logic [W-1:0] d;
        int unsigned  n;
        bit           l;
        logic [15:0]  c;
    } word_t;

    typedef struct {
        int unsigned nw;
        logic [63:0] win;
        int unsigned lb;
        bit          en;
        int unsigned ne;
        logic [63:0] eout;
        int unsigned elb;
        logic [15:0] ecnt;
    } vec_t;

    word_t        rx[$];
    word_t        ex[$];
    logic [W-1:0] nal_w[$];
    int unsigned  nal_lb;
    bit           nal_en;
    int           total = 0;
    int           bad = 0;
    int           bp_mode = 0;
    vec_t         vt[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Downstream ready pattern: 0 always ready, 1 random, 2 stalled.
    initial begin
        bus.bi_next = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       bus.bi_next = 1'b1;
                1:       bus.bi_next = ($urandom_range(0, 3) != 0);
                default: bus.bi_next = 1'b0;
            endcase
        end
    end

    bit               held = 1'b0;
    logic [W+CW:0]    hv;
    initial begin
        forever begin
            @(negedge clk);
            if (reset || !bus.bo_we) begin
                held = 1'b0;
            end else begin
                if (held) chk("hold", 64'({bus.bo_data, bus.bo_bytes, bus.bo_last}), 64'(hv));
                if (bus.bi_next) begin
                    rx.push_back('{bus.bo_data, 32'(bus.bo_bytes), bus.bo_last, epb_cnt});
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hv   = {bus.bo_data, bus.bo_bytes, bus.bo_last};
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at posedge+1; returns at posedge+1 after the word is taken.
    task automatic send_word(input logic [W-1:0] d, input bit first, input bit last,
                             input int unsigned lb, input bit en);
        bit ok;
        ok           = 1'b0;
        bus.ai_we    = 1'b1;
        bus.ai_data  = d;
        bus.ai_first = first;
        bus.ai_last  = last;
        bus.ai_bytes = CW'(lb);
        epb_en       = en;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = bus.ao_next;
            @(posedge clk);
            #1;
        end
        chk("accept", 64'(ok), 64'd1);
        bus.ai_we    = 1'b0;
        bus.ai_first = 1'b0;
        bus.ai_last  = 1'b0;
        bus.ai_bytes = '0;
        bus.ai_data  = '0;
    endtask

    task automatic send_nal(input bit rand_en);
        bit last;
        for (int unsigned i = 0; i < nal_w.size(); i++) begin
            last = (i == nal_w.size() - 1);
            send_word(nal_w[i], (i == 0), last, last ? nal_lb : 0,
                      (i == 0 || !rand_en) ? nal_en : 1'($urandom));
        end
    endtask

    // Reference: apply the byte rules to the NAL as a byte list, then chunk.
    // Full words made only of bytes before the last word stream out early; the rest
    // (prefix remainder plus last-word survivors) is the flush, which always yields a word.
    function automatic void model();
        logic [7:0]   kept[$];
        logic [7:0]   b;
        logic [W-1:0] w;
        logic [W-1:0] o;
        int unsigned  zeros = 0;
        int unsigned  removed = 0;
        int unsigned  p = 0;
        int unsigned  idx = 0;
        int unsigned  rem;
        int unsigned  take;
        int unsigned  nb;
        int unsigned  last_i = nal_w.size() - 1;
        logic [15:0]  c = 16'((removed > 65535) ? 65535 : removed);
        for (int unsigned i = 0; i < nal_w.size(); i++) begin
            w  = nal_w[i];
            nb = (i == last_i) ? nal_lb : B;
            if (i == last_i) p = kept.size();
            for (int unsigned j = 0; j < nb; j++) begin
                b = w[W-1-8*j -: 8];
                if (nal_en && zeros >= 2 && b == 8'h03) begin
                    removed++;
                    zeros = 0;
                end else begin
                    kept.push_back(b);
                    zeros = (b == 8'h00) ? zeros + 1 : 0;
                end
            end
        end
        c = 16'((removed > 65535) ? 65535 : removed);
        for (int unsigned k = 0; k < p / B; k++) begin
            o = '0;
            for (int unsigned j = 0; j < B; j++) o[W-1-8*j -: 8] = kept[idx + j];
            idx += B;
            ex.push_back('{o, B, 1'b0, 16'd0});
        end
        rem = kept.size() - idx;
        do begin
            take = (rem < B) ? rem : B;
            o = '0;
            for (int unsigned j = 0; j < take; j++) o[W-1-8*j -: 8] = kept[idx + j];
            idx += take;
            rem -= take;
            ex.push_back('{o, take, (rem == 0), (rem == 0) ? c : 16'd0});
        end while (rem > 0);
    endfunction

    task automatic run_check(input string name);
        int unsigned guard = 0;
        int unsigned n;
        while (rx.size() < ex.size() && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("%s_count", name), 64'(rx.size()), 64'(ex.size()));
        n = (rx.size() < ex.size()) ? rx.size() : ex.size();
        for (int unsigned k = 0; k < n; k++) begin
            chk($sformatf("%s_word%0d", name, k), 64'({rx[k].d, 8'(rx[k].n), rx[k].l}),
                64'({ex[k].d, 8'(ex[k].n), ex[k].l}));
            if (ex[k].l) chk($sformatf("%s_cnt", name), 64'(rx[k].c), 64'(ex[k].c));
        end
        rx.delete();
        ex.delete();
    endtask

    task automatic apply_vec(input int unsigned v);
        logic [63:0] t;
        bit          last;
        nal_w.delete();
        t = vt[v].win;
        for (int unsigned i = 0; i < vt[v].nw; i++) nal_w.push_back(t[63-16*i -: 16]);
        nal_lb = vt[v].lb;
        nal_en = vt[v].en;
        t = vt[v].eout;
        for (int unsigned k = 0; k < vt[v].ne; k++) begin
            last = (k == vt[v].ne - 1);
            ex.push_back('{t[63-16*k -: 16], last ? vt[v].elb : B, last, last ? vt[v].ecnt : 16'd0});
        end
        send_nal(1'b0);
        run_check($sformatf("vec%0d", v));
    endtask

    task automatic rand_nal(input int unsigned nwords, input int unsigned nbytes_total);
        logic [7:0]   q[$];
        logic [W-1:0] w;
        int unsigned  r;
        while (q.size() < nbytes_total) begin
            r = $urandom_range(0, 3);
            if (r == 0) begin
                q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h03);
            end else if (r == 1) q.push_back(8'h00);
            else if (r == 2) q.push_back(8'h03);
            else q.push_back(8'($urandom));
        end
        nal_w.delete();
        for (int unsigned i = 0; i < nwords; i++) begin
            w = {q[2*i], q[2*i+1]};
            nal_w.push_back(w);
        end
        nal_lb = $urandom_range(1, 2);
    endtask

    initial begin
        vt[0] = '{2, 64'h0000_0301_0000_0000, 2, 1'b1, 2, 64'h0000_0100_0000_0000, 1, 16'd1};
        vt[1] = '{3, 64'h1200_0003_0405_0000, 2, 1'b1, 3, 64'h1200_0004_0500_0000, 1, 16'd1};
        vt[2] = '{4, 64'h0000_0300_0003_AABB, 2, 1'b1, 3, 64'h0000_0000_AABB_0000, 2, 16'd2};
        vt[3] = '{2, 64'h0003_1122_0000_0000, 2, 1'b1, 2, 64'h0003_1122_0000_0000, 2, 16'd0};
        vt[4] = '{2, 64'h0000_0301_0000_0000, 2, 1'b0, 2, 64'h0000_0301_0000_0000, 2, 16'd0};
        vt[5] = '{2, 64'h0000_0300_0000_0000, 1, 1'b1, 2, 64'h0000_0000_0000_0000, 0, 16'd1};
        vt[6] = '{1, 64'h1234_0000_0000_0000, 1, 1'b1, 1, 64'h1200_0000_0000_0000, 1, 16'd0};
        vt[7] = '{1, 64'h0000_0000_0000_0000, 2, 1'b1, 1, 64'h0000_0000_0000_0000, 2, 16'd0};
        vt[8] = '{1, 64'h0301_0000_0000_0000, 2, 1'b1, 1, 64'h0301_0000_0000_0000, 2, 16'd0};

        reset        = 1'b1;
        epb_en       = 1'b0;
        bus.ai_we    = 1'b0;
        bus.ai_first = 1'b0;
        bus.ai_last  = 1'b0;
        bus.ai_bytes = '0;
        bus.ai_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bo_we",    64'(bus.bo_we),    64'd0);
        chk("rst_bo_data",  64'(bus.bo_data),  64'd0);
        chk("rst_bo_last",  64'(bus.bo_last),  64'd0);
        chk("rst_bo_bytes", 64'(bus.bo_bytes), 64'd0);
        chk("rst_epb_cnt",  64'(epb_cnt),      64'd0);
        chk("rst_ao_next",  64'(bus.ao_next),  64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int unsigned v = 0; v < 9; v++) apply_vec(v);

        // Reset while a flush word is stalled downstream.
        bp_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_word(16'h1234, 1'b1, 1'b1, 2, 1'b1);
        @(negedge clk);
        chk("flush_pending", 64'(bus.bo_we), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_bo_we",    64'(bus.bo_we),    64'd0);
        chk("midrst_bo_data",  64'(bus.bo_data),  64'd0);
        chk("midrst_bo_last",  64'(bus.bo_last),  64'd0);
        chk("midrst_bo_bytes", 64'(bus.bo_bytes), 64'd0);
        chk("midrst_ao_next",  64'(bus.ao_next),  64'd1);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        bp_mode = 0;
        chk("midrst_no_leak", 64'(rx.size()), 64'd0);
        rx.delete();
        apply_vec(0);

        // 20-word stream with a 5-cycle downstream stall in the middle.
        rand_nal(20, 40);
        nal_en  = 1'b1;
        model();
        bp_mode = 1;
        fork
            send_nal(1'b1);
            begin
                repeat (6) @(posedge clk);
                bp_mode = 2;
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("stall_ao_next", 64'(bus.ao_next), 64'd0);
                chk("stall_bo_we",   64'(bus.bo_we),   64'd1);
                @(posedge clk);
                bp_mode = 1;
            end
        join
        run_check("bp");

        for (int unsigned r = 0; r < 10; r++) begin
            rand_nal($urandom_range(1, 6), 12);
            nal_en  = 1'($urandom);
            bp_mode = $urandom_range(0, 1);
            model();
            send_nal(1'b1);
            run_check($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
